// File: rtl/priority_arbiter_8_if.sv
// Request/grant bundle between eight clients and the shared-resource arbiter.
// master = client side (drives requests), slave = arbiter side (drives grants).
interface priority_arbiter_8_if;
  logic [7:0] req;
  logic       rr_mode;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (output req, output rr_mode,
                  input  gnt, input gnt_id, input gnt_valid, input timeout);
  modport slave  (input  req, input rr_mode,
                  output gnt, output gnt_id, output gnt_valid, output timeout);
endinterface

// File: rtl/priority_arbiter_8.sv
// Registered 8-requester arbiter: fixed priority (bit 7 highest) or round-robin,
// with a hold-time limit that forces a handover when other clients are waiting.
module priority_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  priority_arbiter_8_if.slave  bus
);

  localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q, state_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       last_q, last_d;

  logic       holder_req, release_ev, timeout_ev, arb_ev;
  logic [7:0] others, cand;
  logic [2:0] fp_id, rr_id, rr_idx, win_id;
  logic       rr_found;

  // Arbitration event detection and candidate selection
  always_comb begin
    holder_req = bus.req[gnt_id_q];
    others     = bus.req & ~gnt_q;
    release_ev = (state_q == GRANT) && !holder_req;
    timeout_ev = (state_q == GRANT) && holder_req && (MAX_HOLD != 0) &&
                 (cnt_q == CNT_MAX) && (others != 8'h00);
    arb_ev     = ((state_q == IDLE) && (bus.req != 8'h00)) || release_ev || timeout_ev;
    cand       = timeout_ev ? others : bus.req;
  end

  // Fixed priority: ascending scan so the highest set index wins
  always_comb begin
    fp_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cand[i]) fp_id = 3'(i);
    end
  end

  // Round-robin: first set bit after the last grant, wrapping mod 8
  always_comb begin
    rr_id    = 3'd0;
    rr_idx   = 3'd0;
    rr_found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      rr_idx = last_q + 3'(k);
      if (!rr_found && cand[rr_idx]) begin
        rr_found = 1'b1;
        rr_id    = rr_idx;
      end
    end
    win_id = bus.rr_mode ? rr_id : fp_id;
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    last_d      = last_q;
    if (arb_ev) begin
      if (cand != 8'h00) begin
        state_d     = GRANT;
        gnt_d       = 8'(8'h01 << win_id);
        gnt_id_d    = win_id;
        gnt_valid_d = 1'b1;
        timeout_d   = timeout_ev;
        cnt_d       = CNT_W'(1);
        last_d      = win_id;
      end else begin
        state_d     = IDLE;
        gnt_d       = 8'h00;
        gnt_id_d    = 3'd0;
        gnt_valid_d = 1'b0;
        cnt_d       = '0;
      end
    end else if (state_q == GRANT && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 8'h00;
      gnt_id_q    <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
      last_q      <= 3'd7;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: doc/priority_arbiter_8.md
# priority_arbiter_8

Registered 8-requester arbiter that shares one downstream resource among eight clients, issuing a one-hot grant plus its encoded index. It uses the same priority convention as the team's 8-to-3 priority encoder: bit 7 highest, encoded index 0-7, valid flag when any grant is active. An optional round-robin mode and a hold-time limit prevent starvation. It sits between the request lines of the client blocks and the mux/enable of the shared resource.

## Interface
- MAX_HOLD, default 16: maximum consecutive cycles one holder keeps the grant while others wait. 0 disables the timeout.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i high means requester i wants or keeps the resource.
- rr_mode  input  1  0 = fixed priority (bit 7 highest), 1 = round-robin. Sampled at each arbitration.
- gnt  output  8  one-hot grant; all zeros when idle.
- gnt_id  output  3  encoded index of the granted requester; 0 when idle.
- gnt_valid  output  1  high while a grant is active; equals |gnt.
- timeout  output  1  one-cycle pulse, asserted in the first cycle of a grant that was forced by hold expiry.

## Operation
- States are IDLE and GRANT. All outputs are registered.
- **Arbitration event.** Arbitration happens at a clock edge in any of these cases:
  - state is IDLE and req != 0;
  - state is GRANT and req[gnt_id] == 0 (release);
  - state is GRANT and a timeout occurs.
- **Candidate set.**
  - On a timeout: req & ~gnt, so the current holder is excluded.
  - Otherwise: req.
- **Fixed priority.** The winner is the highest set index among the candidates.
- **Round-robin.**
  - Search the candidates in the order last+1, last+2, … mod 8; the first set bit wins.
  - last = index of the most recent grant; it resets to 7, so the first search starts at bit 0.
  - last updates on every grant in both modes.
- **Release.** On the release edge:
  - if any candidate exists, the new winner is granted on that same edge (no idle bubble);
  - otherwise state goes to IDLE and gnt, gnt_id and gnt_valid clear.
- **Hold counter** (width clog2(MAX_HOLD+1)):
  - loads 1 on every new grant;
  - increments each cycle the grant is held;
  - saturates at MAX_HOLD.
- **Timeout.** Occurs at the edge where all of these hold:
  - counter == MAX_HOLD;
  - req[gnt_id] == 1;
  - (req & ~gnt) != 0;
  - MAX_HOLD != 0.
- **Sole requester.** If no other requester is present, the holder keeps the grant indefinitely and timeout never pulses.
- **Release and timeout on the same edge.** Release takes precedence, and timeout stays 0.
- **Mid-grant request changes.** Requests appearing or vanishing for non-holders have no effect until the next arbitration event.
- **Reset values.** rst clears gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0, counter = 0, last = 7, state = IDLE. Reset asserted mid-grant drops the grant at that edge.

## Timing
- **Latency.** req sampled at edge N produces gnt at edge N (visible during cycle N+1): one registered cycle from request to grant.
- **Release to next grant.** The holder deasserting req in cycle k removes its grant at the edge ending cycle k. The next winner's grant is visible in cycle k+1.
- **Hold duration.** A contended holder sees gnt_valid for exactly MAX_HOLD cycles before a forced handover. timeout is high only in the first cycle of the new grant.
- **Handshake rule.** The grant is never withdrawn from a holder whose req stays high, except by timeout or rst. Clients must keep req high for the whole transaction.
- **Grant invariants** (hold every cycle):
  - gnt has at most one bit set;
  - gnt == (gnt_valid << gnt_id);
  - gnt is never set for a requester whose req was low at the granting edge.

## Test plan
1. **Reset and first grant.**
   - Stimulus: rst=1 with req=8'hFF for 3 cycles, then release rst.
   - Response: all outputs 0 during reset. First edge after release: gnt=8'h80, gnt_id=7, gnt_valid=1.
2. **Fixed-priority release chain.**
   - Stimulus: rr_mode=0, req=8'b0000_1111, then drop bits 3, 2, 1, 0 one per cycle.
   - Response: gnt_id = 3, 2, 1, 0 on consecutive cycles with no bubble, then gnt_valid=0 on the edge after bit 0 drops.
3. **Forced handover, fixed priority.**
   - Stimulus: MAX_HOLD=4, rr_mode=0, req=8'b1000_0001 held.
   - Response: id 7 for 4 cycles, then id 0 for 4 cycles with timeout=1 in its first cycle, then id 7 again; alternation continues.
4. **Round-robin rotation.**
   - Stimulus: MAX_HOLD=4, rr_mode=1, req=8'hFF held from reset.
   - Response: gnt_id sequence 0, 1, 2, …, 7, 0, each held 4 cycles, with timeout pulsing at every handover.
5. **Sole requester.**
   - Stimulus: MAX_HOLD=4, req=8'h04 held 20 cycles.
   - Response: gnt=8'h04 throughout and timeout never asserts. Raising req[6] afterwards hands over to id 6 at the next edge with timeout=1, since the counter is already saturated.
6. **Reset mid-grant and release-vs-timeout precedence.**
   - Reset mid-grant: grant id 5, assert rst for 1 cycle with req=8'h20 held. Response: outputs clear at the rst edge, and gnt=8'h20 is re-granted one edge after rst falls.
   - Precedence: holder drops req on the timeout edge. Response: normal release, timeout=0.
